// File: rtl/tx_gearbox_66to32.sv
// Transmit gearbox: packs 66-bit blocks into a continuous 32-bit word stream,
// inserting idle blocks whenever no user block is offered at a load slot.
module tx_gearbox_66to32 #(
   parameter logic [63:0] IDLE_PAYLOAD = 64'h7800_0000_0000_0000,
   parameter logic [1:0]  IDLE_HDR     = 2'b10,
   parameter int          CNT_W        = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic [65:0]      frame_i,
   input  logic             frame_valid_i,
   output logic             frame_ready_o,
   output logic [31:0]      dout_o,
   output logic             dout_valid_o,
   output logic [CNT_W-1:0] frames_sent_o,
   output logic [CNT_W-1:0] idles_sent_o
);

   logic [127:0]     sbuf_q, sbuf_d;
   logic [6:0]       lvl_q, lvl_d;
   logic [31:0]      dout_q, dout_d;
   logic             dvld_q;
   logic [CNT_W-1:0] frames_q, frames_d;
   logic [CNT_W-1:0] idles_q, idles_d;

   logic             load;
   logic [65:0]      blk;
   logic [127:0]     work;
   logic [6:0]       work_lvl;

   // A load slot opens whenever fewer than one output word remains buffered.
   assign load          = en_i & (lvl_q < 7'd32);
   assign frame_ready_o = rst_ni & load;
   assign blk           = frame_valid_i ? frame_i : {IDLE_HDR, IDLE_PAYLOAD};

   always_comb begin
      work     = sbuf_q;
      work_lvl = lvl_q;
      sbuf_d   = sbuf_q;
      lvl_d    = lvl_q;
      dout_d   = dout_q;
      frames_d = frames_q;
      idles_d  = idles_q;
      if (load) begin
         // Left-justify the block, then slide it right past the valid bits.
         work     = sbuf_q | ({blk, 62'd0} >> lvl_q);
         work_lvl = lvl_q + 7'd66;
         if (frame_valid_i) begin
            frames_d = frames_q + 1'b1;
         end else begin
            idles_d = idles_q + 1'b1;
         end
      end
      if (en_i) begin
         dout_d = work[127:96];
         sbuf_d = work << 32;
         lvl_d  = work_lvl - 7'd32;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sbuf_q   <= '0;
         lvl_q    <= '0;
         dout_q   <= '0;
         dvld_q   <= 1'b0;
         frames_q <= '0;
         idles_q  <= '0;
      end else begin
         sbuf_q   <= sbuf_d;
         lvl_q    <= lvl_d;
         dout_q   <= dout_d;
         dvld_q   <= en_i;
         frames_q <= frames_d;
         idles_q  <= idles_d;
      end
   end

   assign dout_o        = dout_q;
   assign dout_valid_o  = dvld_q;
   assign frames_sent_o = frames_q;
   assign idles_sent_o  = idles_q;

endmodule

// File: tb/tb_tx_gearbox_66to32.sv
// Bench for tx_gearbox_66to32: directed stimulus feeds a bit-level scoreboard,
// and a monitor pops 32 expected bits for every valid output word.
module tb_tx_gearbox_66to32;

   localparam int CNT_W = 6;
   localparam logic [65:0] IDLE_BLK = {2'b10, 64'h7800_0000_0000_0000};
   localparam logic [65:0] F1       = {2'b01, 64'hDEADBEEF_01234567};

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic [65:0]      frame;
   logic             frame_valid;
   logic             frame_ready_o;
   logic [31:0]      dout_o;
   logic             dout_valid_o;
   logic [CNT_W-1:0] frames_sent_o;
   logic [CNT_W-1:0] idles_sent_o;

   tx_gearbox_66to32 #(.CNT_W(CNT_W)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .en_i          (en),
      .frame_i       (frame),
      .frame_valid_i (frame_valid),
      .frame_ready_o (frame_ready_o),
      .dout_o        (dout_o),
      .dout_valid_o  (dout_valid_o),
      .frames_sent_o (frames_sent_o),
      .idles_sent_o  (idles_sent_o)
   );

   always #5 clk = ~clk;

   int          n_chk  = 0;
   int          n_pass = 0;
   logic        bitq[$];
   logic [31:0] cap[$];
   logic [31:0] last_exp = '0;
   int          ph = 0;
   int          rdy_hi = 0;
   bit          chk_rdy = 0;
   bit          acc = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic push_block(input logic [65:0] b);
      for (int i = 65; i >= 0; i--) bitq.push_back(b[i]);
   endtask

   // Monitor: every presented word must equal the next 32 bits of the stream.
   always @(negedge clk) begin
      logic [31:0] w;
      if (rst_n && dout_valid_o) begin
         if (bitq.size() < 32) begin
            n_chk++;
            $display("FAIL dout_underflow: got %h expected none queued", dout_o);
         end else begin
            w = '0;
            for (int i = 0; i < 32; i++) w = {w[30:0], bitq.pop_front()};
            check("dout", {32'd0, dout_o}, {32'd0, w});
            $display("word %0d: dout=%h exp=%h", cap.size(), dout_o, w);
            cap.push_back(dout_o);
            last_exp = w;
         end
      end
   end

   // One clock cycle; ph tracks the enabled-cycle phase within the 33-cycle period.
   task automatic step();
      logic exp_rdy;
      @(negedge clk);
      acc = frame_valid && frame_ready_o;
      if (!en) begin
         check("ready_when_disabled", {63'd0, frame_ready_o}, 64'd0);
      end else if (chk_rdy) begin
         exp_rdy = (ph < 31) && (ph % 2 == 0);
         check("ready_pattern", {63'd0, frame_ready_o}, {63'd0, exp_rdy});
      end
      if (en && frame_ready_o) rdy_hi++;
      @(posedge clk);
      if (en) ph = (ph == 32) ? 0 : ph + 1;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_dout", {32'd0, dout_o}, 64'd0);
      check("rst_dvalid", {63'd0, dout_valid_o}, 64'd0);
      check("rst_ready", {63'd0, frame_ready_o}, 64'd0);
      check("rst_frames", {58'd0, frames_sent_o}, 64'd0);
      check("rst_idles", {58'd0, idles_sent_o}, 64'd0);
      bitq.delete();
      cap.delete();
      ph = 0;
      en = 1'b0;
      frame_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic single_frame(input string tag);
      push_block(F1);
      for (int i = 0; i < 20; i++) push_block(IDLE_BLK);
      chk_rdy = 1;
      frame = F1;
      frame_valid = 1'b1;
      en = 1'b1;
      step();
      check({tag, "_accept"}, {63'd0, acc}, 64'd1);
      frame_valid = 1'b0;
      repeat (9) step();
      if (cap.size() < 3) begin
         n_chk++;
         $display("FAIL %s_words: got %0d words expected at least 3", tag, cap.size());
      end else begin
         check({tag, "_w0"}, {32'd0, cap[0]}, 64'h77AB6FBB);
         check({tag, "_w1"}, {32'd0, cap[1]}, 64'hC048D159);
         check({tag, "_w2"}, {32'd0, cap[2]}, 64'hE7800000);
      end
      check({tag, "_frames"}, {58'd0, frames_sent_o}, 64'd1);
      check({tag, "_idles"}, {58'd0, idles_sent_o}, 64'd4);
   endtask

   initial begin
      int accepted;
      int seq;
      bit stalled;
      rst_n = 1'b0;
      en = 1'b0;
      frame = '0;
      frame_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      single_frame("single");

      // Idle fill, including counter wrap at 2^CNT_W idles.
      do_reset();
      for (int i = 0; i < 80; i++) push_block(IDLE_BLK);
      en = 1'b1;
      rdy_hi = 0;
      repeat (33) step();
      check("idle_rdy_period1", rdy_hi, 64'd16);
      rdy_hi = 0;
      repeat (33) step();
      check("idle_rdy_period2", rdy_hi, 64'd16);
      check("idle_count_66", {58'd0, idles_sent_o}, 64'd32);
      check("idle_frames", {58'd0, frames_sent_o}, 64'd0);
      if (cap.size() > 0) check("idle_w0", {32'd0, cap[0]}, 64'h9E000000);
      else begin n_chk++; $display("FAIL idle_w0: got no word expected 9e000000"); end
      repeat (66) step();
      check("idle_count_wrap", {58'd0, idles_sent_o}, 64'd0);

      // Back-pressure with continuous valid, plus a 5-cycle enable stall at lvl 30.
      do_reset();
      seq = 0;
      accepted = 0;
      stalled = 0;
      frame = {2'b01, 64'(seq)};
      push_block(frame);
      frame_valid = 1'b1;
      en = 1'b1;
      for (int c = 0; c < 150; c++) begin
         if (!stalled && c > 40 && ph == 30) begin
            stalled = 1;
            en = 1'b0;
            for (int s = 0; s < 5; s++) begin
               step();
               check("stall_dvalid", {63'd0, dout_valid_o}, 64'd0);
               check("stall_dout_hold", {32'd0, dout_o}, {32'd0, last_exp});
               if (acc) begin
                  n_chk++;
                  $display("FAIL stall_accept: got transfer expected none");
               end
            end
            en = 1'b1;
         end
         step();
         if (acc) begin
            accepted++;
            seq++;
            frame = {(seq % 2 == 0) ? 2'b01 : 2'b10, 64'h0123_0000_0000_0000 + 64'(seq)};
            push_block(frame);
         end
      end
      check("bp_stalled", {63'd0, stalled}, 64'd1);
      check("bp_frames", {58'd0, frames_sent_o}, 64'(accepted % 64));
      check("bp_idles", {58'd0, idles_sent_o}, 64'd0);

      // Asynchronous reset between edges, then restart from a block boundary.
      #2;
      do_reset();
      single_frame("restart");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/tx_gearbox_66to32.md
# tx_gearbox_66to32

Transmit-side 66b→32b gearbox for the Aurora-style 64b/66b link. It accepts 66-bit blocks (2-bit sync header plus 64-bit payload) over a valid/ready handshake and emits one 32-bit word per enabled cycle toward the serializer. When no block is offered, it inserts IDLE blocks, so the serial stream never carries a gap. It is the transmit counterpart of the receive gearbox and header-seeker chain, and it drives the SEE test link and the loopback benches that exercise that chain.

## Interface
- `IDLE_PAYLOAD`, default 64'h7800_0000_0000_0000: payload of inserted idle blocks.
- `IDLE_HDR`, default 2'b10: sync header of inserted idle blocks.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk_i` input 1: system clock; all logic is on the rising edge.
- `rst_ni` input 1: asynchronous, active-low reset.
- `en_i` input 1: gearbox enable. Low stalls the block and holds all state.
- `frame_i` input 66: block to send, laid out as {hdr[1:0], payload[63:0]}. Bit 65 is sent first.
- `frame_valid_i` input 1: `frame_i` is valid.
- `frame_ready_o` output 1: the block will consume a frame this cycle.
- `dout_o` output 32: output word. Bit 31 is sent first.
- `dout_valid_o` output 1: `dout_o` holds a new word.
- `frames_sent_o` output CNT_W: count of user frames consumed; wraps.
- `idles_sent_o` output CNT_W: count of idle blocks inserted; wraps.

## Operation
- Internal state:
  - 128-bit left-justified bit buffer `buf`.
  - 7-bit level `lvl`, giving the valid bits in `buf`; always ≤ 64 between cycles.
- `frame_ready_o = rst_ni & en_i & (lvl < 32)`. It is combinational from registers only and never depends on `frame_valid_i`.
- Load cycle (`en_i` and `lvl < 32`):
  - Block B is `frame_i` if `frame_valid_i`, else {IDLE_HDR, IDLE_PAYLOAD}.
  - B is appended immediately after the `lvl` valid bits.
  - Working level becomes `lvl + 66`.
  - `frames_sent_o` or `idles_sent_o` increments, matching the source of B.
- Every enabled cycle, after any load:
  - The top 32 bits of the working buffer go to `dout_o`.
  - The buffer shifts left 32.
  - `lvl` becomes working level − 32.
- Disabled cycle (`en_i = 0`): `buf`, `lvl` and the counters hold. `dout_o` holds its last value.
- Steady state:
  - From `lvl = 0`, the level sequence is 0,34,2,36,4,…,30,64,32,0.
  - The period is 33 enabled cycles, consuming 16 blocks and producing 33 words (1056 bits each way).
  - `lvl` is always even. The maximum working level is 96.
- Bit ordering is preserved end to end: header bit 1 is the first bit on the line. The receiver sees every block header on a fixed bit phase within the 66-bit period.
- No state machine beyond the level counter. The level alone decides the 33-cycle pattern.

## Timing
- Reset (`rst_ni` low, asynchronous):
  - `buf` = 0, `lvl` = 0.
  - `dout_o` = 0, `dout_valid_o` = 0.
  - `frames_sent_o` = 0, `idles_sent_o` = 0.
  - `frame_ready_o` = 0.
- First enabled cycle after reset release: a load cycle. `frame_ready_o` is 1 in that same cycle.
- Latency: a block accepted at edge N starts appearing on `dout_o` after edge N (registered output, one cycle).
- `dout_valid_o` is registered `en_i`: it is 1 in the cycle after each enabled cycle, else 0.
- Handshake:
  - A transfer occurs on an edge where `frame_valid_i & frame_ready_o`.
  - A frame offered while ready is low is not consumed; the source must hold it.
  - Valid arriving in a ready cycle after an idle was due is too late. The idle is sent that cycle and the frame goes at the next load.
- `en_i` toggling mid-period resumes exactly where it stopped, with no bits lost or duplicated.
- Reset mid-period discards the buffered bits. The next stream starts at a block boundary.
- Counters wrap from 2^CNT_W−1 to 0 with no saturation.

## Test plan
- Single frame: after reset, `en_i` = 1, and frame {2'b01, 64'hDEADBEEF_01234567} valid in the first cycle only. Required response:
  - `dout_o` is 32'h77AB6FBB, then 32'hC048D159.
  - The next word starts with bits "11", followed by idle bits.
  - `frames_sent_o` = 1.
- Idle fill: `frame_valid_i` held 0 for 66 cycles. Required response:
  - The first word is 32'h9E000000.
  - `idles_sent_o` = 32 after 66 enabled cycles.
  - `frame_ready_o` pattern repeats every 33 cycles with exactly 16 highs.
- Back-pressure: `frame_valid_i` held 1 with an incrementing payload. Required response:
  - Ready is low on 17 of every 33 cycles.
  - No frame is lost or duplicated; the reassembled stream equals the input sequence.
- Enable stall: deassert `en_i` for 5 cycles at `lvl` = 30. Required response:
  - `dout_valid_o` is 0 for those 5 cycles, then the word stream continues bit-exact.
- Async reset mid-period: pulse `rst_ni` low between edges. Required response:
  - All outputs read 0 immediately.
  - The restart output matches the single-frame case.
- Loopback: connect to the receive gearbox and seeker chain with random valid frames. Required response:
  - `is_synced` asserts.
  - `offset_pos` stays constant for 1000 blocks.
